// File: rtl/brick_pkg.sv
// Shared constants, state encoding and scoring helper for the brick field.
package brick_pkg;

    localparam int NUM_BLOCKS = 15;
    localparam int ROW_SIZE   = 5;
    localparam int SCORE_W    = 10;

    localparam logic [NUM_BLOCKS-1:0] ALIVE_FULL = 15'h7FFF;

    localparam logic [1:0] PTS_ROW0 = 2'd3;
    localparam logic [1:0] PTS_ROW1 = 2'd2;
    localparam logic [1:0] PTS_ROW2 = 2'd1;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        WIN
    } field_state_t;

    // Top rows are harder to reach, so they are worth more.
    function automatic logic [1:0] row_points(input logic [1:0] row);
        logic [1:0] pts;
        case (row)
            2'd0:    pts = PTS_ROW0;
            2'd1:    pts = PTS_ROW1;
            default: pts = PTS_ROW2;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/brick_field_ctrl_hit_select.sv
// Lowest-index priority encoder over the brick hit vector, with row lookup.
module hit_select
    import brick_pkg::*;
(
    input  logic [NUM_BLOCKS-1:0] req_i,
    output logic                  valid_o,
    output logic [3:0]            index_o,
    output logic [1:0]            row_o
);

    // Scan from the top down so the last assignment is the lowest set bit.
    always_comb begin
        valid_o = |req_i;
        index_o = 4'd0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                index_o = 4'(i);
            end
        end
    end

    always_comb begin
        row_o = 2'd2;
        if (index_o < 4'(ROW_SIZE)) begin
            row_o = 2'd0;
        end else if (index_o < 4'(2 * ROW_SIZE)) begin
            row_o = 2'd1;
        end
    end

endmodule

// File: rtl/brick_field_ctrl.sv
// Brick field owner: alive mask, scoring, block/paddle bounce requests and win tracking.
module brick_field_ctrl
    import brick_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  new_game_i,
    input  logic                  frame_tick_i,
    input  logic [NUM_BLOCKS-1:0] collide_block_i,
    input  logic                  collide_paddle_i,
    output logic [NUM_BLOCKS-1:0] alive_o,
    output logic                  bounce_block_o,
    output logic                  bounce_paddle_o,
    output logic [SCORE_W-1:0]    score_o,
    output logic [3:0]            blocks_left_o,
    output logic                  win_o
);

    field_state_t          state_q, state_d;
    logic [NUM_BLOCKS-1:0] alive_q, alive_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [3:0]            blocksLeft_q, blocksLeft_d;
    logic                  lockout_q, lockout_d;
    logic                  bounceBlock_q, bounceBlock_d;
    logic                  bouncePaddle_q, bouncePaddle_d;
    logic                  paddlePrev_q, paddlePrev_d;

    logic [NUM_BLOCKS-1:0] hits;
    logic                  hitValid;
    logic [3:0]            hitIdx;
    logic [1:0]            hitRow;
    logic [SCORE_W:0]      scoreSum;
    logic [SCORE_W-1:0]    scoreSat;

    // Bits already cleared are masked so a lingering collide flag never double counts.
    assign hits = collide_block_i & alive_q;

    hit_select u_hit_select (
        .req_i   (hits),
        .valid_o (hitValid),
        .index_o (hitIdx),
        .row_o   (hitRow)
    );

    assign scoreSum = {1'b0, score_q} + {{(SCORE_W - 1){1'b0}}, row_points(hitRow)};
    assign scoreSat = scoreSum[SCORE_W] ? {SCORE_W{1'b1}} : scoreSum[SCORE_W-1:0];

    always_comb begin
        state_d        = state_q;
        alive_d        = alive_q;
        score_d        = score_q;
        blocksLeft_d   = blocksLeft_q;
        lockout_d      = frame_tick_i ? 1'b0 : lockout_q;
        bounceBlock_d  = 1'b0;
        bouncePaddle_d = (state_q == PLAY) && collide_paddle_i && !paddlePrev_q;
        paddlePrev_d   = collide_paddle_i;

        case (state_q)
            IDLE, WIN: begin
                if (new_game_i) begin
                    state_d      = PLAY;
                    alive_d      = ALIVE_FULL;
                    score_d      = '0;
                    blocksLeft_d = 4'(NUM_BLOCKS);
                    lockout_d    = 1'b0;
                end
            end
            PLAY: begin
                if (new_game_i) begin
                    alive_d      = ALIVE_FULL;
                    score_d      = '0;
                    blocksLeft_d = 4'(NUM_BLOCKS);
                    lockout_d    = 1'b0;
                end else if (blocksLeft_q == 4'd0) begin
                    state_d = WIN;
                end else if (hitValid) begin
                    alive_d       = alive_q & ~(15'b1 << hitIdx);
                    blocksLeft_d  = blocksLeft_q - 4'd1;
                    score_d       = scoreSat;
                    // A same-cycle frame tick re-arms the bounce before this hit consumes it.
                    bounceBlock_d = !lockout_q || frame_tick_i;
                    lockout_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            alive_q        <= ALIVE_FULL;
            score_q        <= '0;
            blocksLeft_q   <= 4'(NUM_BLOCKS);
            lockout_q      <= 1'b0;
            bounceBlock_q  <= 1'b0;
            bouncePaddle_q <= 1'b0;
            paddlePrev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            alive_q        <= alive_d;
            score_q        <= score_d;
            blocksLeft_q   <= blocksLeft_d;
            lockout_q      <= lockout_d;
            bounceBlock_q  <= bounceBlock_d;
            bouncePaddle_q <= bouncePaddle_d;
            paddlePrev_q   <= paddlePrev_d;
        end
    end

    assign alive_o         = alive_q;
    assign score_o         = score_q;
    assign blocks_left_o   = blocksLeft_q;
    assign bounce_block_o  = bounceBlock_q;
    assign bounce_paddle_o = bouncePaddle_q;
    assign win_o           = (state_q == WIN);

endmodule
